// File: rtl/hyperram_arb_pkg.sv
// Shared types and constants for the two-port HyperRAM arbiter.
// Port 0 is the SoC memory port and port 1 is the FT601Q DMA engine.
package hyperram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } arbState_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int DEF_ADDR_W = 23;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 8;

  // One-hot strobe vector for a single port index.
  function automatic logic [1:0] portMask(input logic port);
    portMask = port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/hyperram_arb_pick.sv
// Combinational winner select for the HyperRAM arbiter.
// Config macro HYPERRAM_ARB_RR_EN: defined = round-robin ties, undefined = port 0 fixed priority.
module hyperram_arb_pick
  import hyperram_arb_pkg::*;
(
  input  logic [1:0] reqValid,
  input  logic       owner,
  output logic       winner
);

  // Pick the winner; with no request pending the last owner is simply kept.
  always_comb begin
    winner = owner;
    if (reqValid == 2'b11) begin
`ifdef HYPERRAM_ARB_RR_EN
      winner = ~owner;
`else
      winner = PORT_CPU;
`endif
    end else if (reqValid[0]) begin
      winner = PORT_CPU;
    end else if (reqValid[1]) begin
      winner = PORT_DMA;
    end else begin
      winner = owner;
    end
  end

endmodule

// File: rtl/hyperram_arbiter.sv
// Shares one HyperRAM controller command/data interface between the SoC port (0) and the DMA port (1).
// Tie policy is chosen in hyperram_arb_pick via the HYPERRAM_ARB_RR_EN macro.
module hyperram_arbiter
  import hyperram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*LEN_W-1:0]  req_len,
  input  logic [2*DATA_W-1:0] req_wdata,
  input  logic [1:0]          req_wvalid,
  output logic [1:0]          req_wready,
  output logic [DATA_W-1:0]   req_rdata,
  output logic [1:0]          req_rvalid,
  output logic [1:0]          req_done,
  output logic                busy,
  output logic                owner,
  output logic                mem_cmd_valid,
  input  logic                mem_cmd_ready,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [LEN_W-1:0]    mem_len,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_wvalid,
  input  logic                mem_wready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid,
  input  logic                mem_done
);

  arbState_t         state;
  logic [LEN_W:0]    beatCnt;
  logic              winner;
  logic [ADDR_W-1:0] winAddr;
  logic [LEN_W-1:0]  winLen;
  logic              winWrite;
  logic              inData;
  logic              beatOpen;
  logic              ownWvalid;
  logic              wreadyOwn;
  logic              rvalidOwn;
  logic              doneOwn;
  logic              beatFire;

  hyperram_arb_pick uPick (
    .reqValid (req_valid),
    .owner    (owner),
    .winner   (winner)
  );

  // Command fields of the selected requester, sampled on the grant edge.
  always_comb begin
    winAddr  = winner ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    winLen   = winner ? req_len[2*LEN_W-1:LEN_W]    : req_len[LEN_W-1:0];
    winWrite = winner ? req_write[1]                : req_write[0];
  end

  // Beat routing: the window stays open for len+1 beats (beatCnt is one bit wider so 256 beats fit).
  always_comb begin
    inData     = (state == DATA);
    beatOpen   = inData && (beatCnt <= {1'b0, mem_len});
    ownWvalid  = owner ? req_wvalid[1] : req_wvalid[0];
    mem_wdata  = owner ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    mem_wvalid = beatOpen && mem_write && ownWvalid;
    wreadyOwn  = beatOpen && mem_write && mem_wready;
    rvalidOwn  = beatOpen && !mem_write && mem_rvalid;
    doneOwn    = inData && mem_done;
    req_rdata  = mem_rdata;
    if (mem_write) begin
      beatFire = wreadyOwn && ownWvalid;
    end else begin
      beatFire = rvalidOwn;
    end
  end

  // Fan the owner's strobes out; the non-owner bit is always zero.
  always_comb begin
    req_wready = wreadyOwn ? portMask(owner) : 2'b00;
    req_rvalid = rvalidOwn ? portMask(owner) : 2'b00;
    req_done   = doneOwn   ? portMask(owner) : 2'b00;
  end

  // Grant / command / data sequencing with registered status and command outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      req_ready     <= 2'b00;
      owner         <= PORT_DMA;
      busy          <= 1'b0;
      mem_cmd_valid <= 1'b0;
      mem_write     <= 1'b0;
      mem_addr      <= {ADDR_W{1'b0}};
      mem_len       <= {LEN_W{1'b0}};
      beatCnt       <= {(LEN_W+1){1'b0}};
    end else begin
      req_ready <= 2'b00;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state         <= CMD;
            owner         <= winner;
            req_ready     <= portMask(winner);
            busy          <= 1'b1;
            mem_cmd_valid <= 1'b1;
            mem_write     <= winWrite;
            mem_addr      <= winAddr;
            mem_len       <= winLen;
            beatCnt       <= {(LEN_W+1){1'b0}};
          end
        end
        CMD: begin
          if (mem_cmd_ready) begin
            state         <= DATA;
            mem_cmd_valid <= 1'b0;
          end
        end
        DATA: begin
          if (beatFire) begin
            beatCnt <= beatCnt + {{LEN_W{1'b0}}, 1'b1};
          end
          // An early mem_done still ends the burst.
          if (mem_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          mem_cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hyperram_arbiter.sv
// Self-checking bench for hyperram_arbiter: transaction-level model compared every cycle plus literal checks.
// Honors HYPERRAM_ARB_RR_EN for the expected tie-break result.
module tb_hyperram_arbiter;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int LW = 8;

`ifdef HYPERRAM_ARB_RR_EN
  localparam logic [1:0] TIE_AFTER_CPU = 2'b10;
`else
  localparam logic [1:0] TIE_AFTER_CPU = 2'b01;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn = 1'b0;
  logic [1:0]    req_valid = 2'b00, req_ready, req_write = 2'b00;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*LW-1:0] req_len = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]    req_wvalid = 2'b00, req_wready, req_rvalid, req_done;
  logic [DW-1:0] req_rdata;
  logic          busy, owner, mem_cmd_valid, mem_cmd_ready = 1'b0, mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_len;
  logic [DW-1:0] mem_wdata, mem_rdata = '0;
  logic          mem_wvalid, mem_wready = 1'b0, mem_rvalid = 1'b0, mem_done = 1'b0;

  hyperram_arbiter dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .req_wvalid(req_wvalid), .req_wready(req_wready), .req_rdata(req_rdata),
    .req_rvalid(req_rvalid), .req_done(req_done), .busy(busy), .owner(owner),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_done(mem_done)
  );

  int passCnt = 0;
  int totalCnt = 0;
  int cyc = 0;
  int wBeats = 0;
  int rBeats1 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level model: one outstanding burst, described by who owns it and how far it got.
  bit          mBusy = 1'b0, mCmd = 1'b0, mOwner = 1'b1, mWrite = 1'b0;
  logic [AW-1:0] mAddr = '0;
  logic [LW-1:0] mLen = '0;
  logic [1:0]  mGrant = 2'b00;
  int          mBeats = 0;

  function automatic bit modelPick(input logic [1:0] v, input bit lastOwner);
`ifdef HYPERRAM_ARB_RR_EN
    if (v == 2'b11) return !lastOwner;
`endif
    return v[0] ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [1:0] toMask(input bit port, input bit on);
    if (!on) return 2'b00;
    return port ? 2'b10 : 2'b01;
  endfunction

  wire          mWin    = modelPick(req_valid, mOwner);
  wire          mData   = mBusy && !mCmd;
  wire          mOpen   = mData && (mBeats <= int'(mLen));
  wire          eWvalid = mOpen && mWrite && req_wvalid[mOwner];
  wire          eWready = mOpen && mWrite && mem_wready;
  wire          eRvalid = mOpen && !mWrite && mem_rvalid;
  wire [DW-1:0] eWdata  = mOwner ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];

  always @(posedge clk) begin
    if (!resetn) begin
      mBusy <= 1'b0; mCmd <= 1'b0; mOwner <= 1'b1; mWrite <= 1'b0;
      mAddr <= '0; mLen <= '0; mGrant <= 2'b00; mBeats <= 0;
    end else begin
      mGrant <= 2'b00;
      if (!mBusy) begin
        if (req_valid != 2'b00) begin
          mBusy  <= 1'b1;
          mCmd   <= 1'b1;
          mOwner <= mWin;
          mGrant <= toMask(mWin, 1'b1);
          mWrite <= req_write[mWin];
          mAddr  <= mWin ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
          mLen   <= mWin ? req_len[2*LW-1:LW] : req_len[LW-1:0];
          mBeats <= 0;
        end
      end else if (mCmd) begin
        if (mem_cmd_ready) mCmd <= 1'b0;
      end else begin
        if ((eWvalid && mem_wready) || eRvalid) mBeats <= mBeats + 1;
        if (mem_done) mBusy <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (resetn) begin
      if (mem_wvalid && mem_wready) wBeats++;
      if (req_rvalid[1]) rBeats1++;
      chk("busy", busy, mBusy);
      chk("owner", owner, mOwner);
      chk("req_ready", req_ready, mGrant);
      chk("mem_cmd_valid", mem_cmd_valid, mBusy && mCmd);
      chk("mem_write", mem_write, mWrite);
      chk("mem_addr", mem_addr, mAddr);
      chk("mem_len", mem_len, mLen);
      chk("mem_wvalid", mem_wvalid, eWvalid);
      chk("req_wready", req_wready, toMask(mOwner, eWready));
      chk("req_rvalid", req_rvalid, toMask(mOwner, eRvalid));
      chk("req_done", req_done, toMask(mOwner, mData && mem_done));
      if (eWvalid) chk("mem_wdata", mem_wdata, eWdata);
      if (eRvalid) chk("req_rdata", req_rdata, mem_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int grantCyc = 0;

  task automatic waitGrant(input logic [1:0] exp, input string name);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (req_ready != 2'b00) break;
    end
    grantCyc = cyc;
    chk(name, req_ready, exp);
  endtask

  task automatic cmdAccept();
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0;
  endtask

  task automatic readBurst(input logic [1:0] exp, input string name, input logic [1:0] afterValid);
    waitGrant(exp, name);
    req_valid = afterValid;
    cmdAccept();
    mem_rvalid = 1'b1;
    mem_rdata = $urandom;
    tick();
    mem_rvalid = 1'b0;
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int dCyc;

  initial begin
    repeat (3) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 1'b1);
    chk("rst_cmd_valid", mem_cmd_valid, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_mem_addr", mem_addr, 23'h0);
    resetn = 1'b1;
    tick();

    // Port 0 write, addr 0x100, len 3: four beats then done.
    req_valid = 2'b01; req_write = 2'b01;
    req_addr[AW-1:0] = 23'h000100; req_len[LW-1:0] = 8'd3;
    waitGrant(2'b01, "t1_grant");
    chk("t1_addr", mem_addr, 23'h000100);
    chk("t1_len", mem_len, 8'd3);
    chk("t1_cmd_valid", mem_cmd_valid, 1'b1);
    req_valid = 2'b00;
    cmdAccept();
    wBeats = 0;
    req_wvalid = 2'b01; mem_wready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_wdata[DW-1:0] = 32'hA000_0000 + i;
      tick();
    end
    req_wvalid = 2'b00; mem_wready = 1'b0; mem_done = 1'b1;
    #1 chk("t1_done", req_done, 2'b01);
    tick();
    mem_done = 1'b0;
    chk("t1_beats", wBeats, 4);
    chk("t1_idle", busy, 1'b0);

    // Port 0 write len 1 with three wready cycles: only two beats pass.
    req_valid = 2'b01; req_addr[AW-1:0] = 23'h002000; req_len[LW-1:0] = 8'd1;
    waitGrant(2'b01, "t2_grant");
    req_valid = 2'b00;
    cmdAccept();
    wBeats = 0;
    req_wvalid = 2'b01; mem_wready = 1'b1;
    repeat (3) tick();
    chk("t2_wready_closed", req_wready, 2'b00);
    chk("t2_wvalid_closed", mem_wvalid, 1'b0);
    chk("t2_beats", wBeats, 2);
    req_wvalid = 2'b00; mem_wready = 1'b0; mem_done = 1'b1;
    tick();
    mem_done = 1'b0;

    // Port 1 read len 255 with 257 downstream beats: exactly 256 forwarded.
    req_valid = 2'b10; req_write = 2'b00;
    req_addr[2*AW-1:AW] = 23'h7FFF00; req_len[2*LW-1:LW] = 8'd255;
    waitGrant(2'b10, "t3_grant");
    chk("t3_len", mem_len, 8'd255);
    chk("t3_addr", mem_addr, 23'h7FFF00);
    req_valid = 2'b00;
    cmdAccept();
    rBeats1 = 0;
    mem_rvalid = 1'b1;
    for (int i = 0; i < 257; i++) begin
      mem_rdata = 32'h0000_0001 + i * 3;
      tick();
    end
    mem_rvalid = 1'b0; mem_done = 1'b1;
    #1 chk("t3_done", req_done, 2'b10);
    tick();
    mem_done = 1'b0;
    chk("t3_rbeats", rBeats1, 256);

    // Back-to-back: port 1 waits behind port 0; grant lands two cycles after mem_done.
    req_len = '0;
    req_valid = 2'b11;
    waitGrant(2'b01, "t4_grant0");
    req_valid = 2'b10;
    cmdAccept();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0; mem_done = 1'b1;
    dCyc = cyc;
    tick();
    mem_done = 1'b0;
    waitGrant(2'b10, "t4_grant1");
    chk("t4_turnaround", grantCyc - dCyc, 2);
    req_valid = 2'b00;
    cmdAccept();
    mem_done = 1'b1;
    #1 chk("t4_early_done", req_done, 2'b10);
    tick();
    mem_done = 1'b0;

    // Ties after reset: port 0 first, then port 1, then port 0, then policy-dependent.
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    req_valid = 2'b11;
    readBurst(2'b01, "t5_tie_first", 2'b10);
    readBurst(2'b10, "t5_second", 2'b11);
    readBurst(2'b01, "t5_tie_repeat", 2'b11);
    readBurst(TIE_AFTER_CPU, "t5_tie_policy", 2'b00);

    // Reset in the middle of a port 1 read burst.
    req_valid = 2'b10; req_len[2*LW-1:LW] = 8'd7;
    waitGrant(2'b10, "t6_grant");
    req_valid = 2'b00;
    cmdAccept();
    mem_rvalid = 1'b1;
    repeat (2) tick();
    mem_rvalid = 1'b0;
    resetn = 1'b0;
    tick();
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_done", req_done, 2'b00);
    chk("t6_rst_owner", owner, 1'b1);
    chk("t6_rst_cmd_valid", mem_cmd_valid, 1'b0);
    resetn = 1'b1;
    req_valid = 2'b01;
    readBurst(2'b01, "t6_fresh_grant", 2'b00);

    repeat (2) tick();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
